// File: rtl/alu_result_fifo.sv
// Circular result FIFO between the 4-bit ALU and its writeback consumer.
// Optional rejected-push counter enabled by defining ALU_RESFIFO_DROP_CNT_EN.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_result,
  input  logic             in_carry,
  input  logic [3:0]       in_rem,
  input  logic [3:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic             out_carry,
  output logic [3:0]       out_rem,
  output logic [3:0]       out_opcode,
  output logic             out_zero,
  output logic [CNT_W-1:0] level
`ifdef ALU_RESFIFO_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic [3:0] rem;
    logic [3:0] opcode;
  } entry_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  entry_t           mem [DEPTH];
  entry_t           head;
  logic             push, pop;

  // Handshakes come from the registered state only, so there is no full-bypass path.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_nxt = PARTIAL;
        PARTIAL: begin
          if (push && !pop && level == CNT_W'(DEPTH - 1)) state_nxt = FULL;
          else if (pop && !push && level == CNT_W'(1))    state_nxt = EMPTY;
        end
        FULL:    if (pop) state_nxt = PARTIAL;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= '{result: in_result, carry: in_carry, rem: in_rem, opcode: in_opcode};
    end
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign out_result = head.result;
  assign out_carry  = head.carry;
  assign out_rem    = head.rem;
  assign out_opcode = head.opcode;
  assign out_zero   = out_valid && (head.result == 8'h00);

`ifdef ALU_RESFIFO_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= '0;
    end else if (in_valid && !in_ready && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule
